fop64_alu_sequencer: RTL and testbench



---
 rtl/fop64_alu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fop64_alu_sequencer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fop64_alu_sequencer.sv
`timescale 1ns/1ps
// fop64_alu_sequencer
// Sequential initiator for the FOP64 ALU. It accepts one command on a
// valid/ready channel, drives the ALU's combinational inputs, and waits
// SETTLE_CYCLES edges. It then captures the ALU outputs and returns them on
// a valid/ready response channel together with the command's tag. Only one
// transaction is in flight at a time.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_code/opm/a/b/tag command payload
//   alu_cmd/opm/a/b      registered drive into the ALU
//   alu_out/regF/error   ALU results, sampled only on the capture edge
//   rsp_valid/rsp_ready  response handshake
//   rsp_out/flags/error  captured ALU results
//   rsp_neg/zero/fault   regF[9], regF[11], |error at capture
//   rsp_tag              tag of the completed command
//   busy                 high while a transaction is in DRIVE or RESP
//   txn_count            completed responses, wraps modulo 2^16
//   fault_count          completed responses with rsp_fault set, saturating
module fop64_alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned TAG_W         = 4,
  parameter logic [4:0]  IDLE_CMD      = 5'b11111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_code,
  input  logic [6:0]       cmd_opm,
  input  logic [63:0]      cmd_a,
  input  logic [63:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [4:0]       alu_cmd,
  output logic [6:0]       alu_opm,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  input  logic [63:0]      alu_out,
  input  logic [63:0]      alu_regF,
  input  logic [63:0]      alu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_out,
  output logic [63:0]      rsp_flags,
  output logic [63:0]      rsp_error,
  output logic             rsp_neg,
  output logic             rsp_zero,
  output logic             rsp_fault,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      txn_count,
  output logic [15:0]      fault_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("fop64_alu_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       settle_cnt;
  logic [TAG_W-1:0] tag_q;

  logic accept;
  logic capture;
  logic complete;

  // cmd_ready and rsp_valid are registered copies of the state decode, so
  // these handshake terms are equivalent to the port-level handshakes.
  assign accept   = (state == ST_IDLE)  && cmd_valid;
  assign capture  = (state == ST_DRIVE) && (settle_cnt == 4'd1);
  assign complete = (state == ST_RESP)  && rsp_ready;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; a path that left state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)   state_nxt = ST_DRIVE;
      ST_DRIVE: if (capture)  state_nxt = ST_RESP;
      ST_RESP:  if (complete) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      alu_cmd     <= IDLE_CMD;
      alu_opm     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      settle_cnt  <= '0;
      tag_q       <= '0;
      rsp_out     <= '0;
      rsp_flags   <= '0;
      rsp_error   <= '0;
      rsp_neg     <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_fault   <= 1'b0;
      rsp_tag     <= '0;
      txn_count   <= '0;
      fault_count <= '0;
    end else begin
      // Status outputs follow the next state so they are true flop outputs.
      cmd_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);

      if (accept) begin
        alu_cmd    <= cmd_code;
        alu_opm    <= cmd_opm;
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        tag_q      <= cmd_tag;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == ST_DRIVE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end

      // The ALU results are only looked at here; anything they do on other
      // edges has no effect.
      if (capture) begin
        rsp_out   <= alu_out;
        rsp_flags <= alu_regF;
        rsp_error <= alu_error;
        rsp_neg   <= alu_regF[9];
        rsp_zero  <= alu_regF[11];
        rsp_fault <= |alu_error;
        rsp_tag   <= tag_q;
        rsp_valid <= 1'b1;
        alu_cmd   <= IDLE_CMD;
        alu_opm   <= '0;
        alu_a     <= '0;
        alu_b     <= '0;
      end

      // Response fields are left untouched after the handshake so the last
      // result stays readable.
      if (complete) begin
        rsp_valid <= 1'b0;
        txn_count <= txn_count + 16'd1;
        if (rsp_fault && (fault_count != 16'hFFFF)) begin
          fault_count <= fault_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fop64_alu_sequencer.sv
`timescale 1ns/1ps
// Bench for fop64_alu_sequencer. Instance 0 runs with SETTLE_CYCLES=1 and
// instance 1 with SETTLE_CYCLES=3; each has its own behavioural ALU.
module tb_fop64_alu_sequencer;

  localparam logic [4:0] IDLE_CMD = 5'b11111;
  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00100;
  localparam logic [4:0] OP_OR    = 5'b00101;
  localparam logic [4:0] OP_XOR   = 5'b00110;
  localparam logic [4:0] OP_TRAP  = 5'b00111;

  typedef struct packed {
    logic [63:0] out;
    logic [63:0] flags;
    logic [63:0] err;
  } alu_res_t;

  typedef struct {
    logic [4:0]  code;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
    int          hold;
    logic [63:0] exp_out;
    logic        exp_zero;
    logic        exp_neg;
    logic        exp_fault;
  } vec_t;

  logic        clk;
  logic        rst_n       [2];
  logic        cmd_valid   [2];
  logic        cmd_ready   [2];
  logic [4:0]  cmd_code    [2];
  logic [6:0]  cmd_opm     [2];
  logic [63:0] cmd_a       [2];
  logic [63:0] cmd_b       [2];
  logic [3:0]  cmd_tag     [2];
  logic [4:0]  alu_cmd     [2];
  logic [6:0]  alu_opm     [2];
  logic [63:0] alu_a       [2];
  logic [63:0] alu_b       [2];
  alu_res_t    alu_res     [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [63:0] rsp_out     [2];
  logic [63:0] rsp_flags   [2];
  logic [63:0] rsp_error   [2];
  logic        rsp_neg     [2];
  logic        rsp_zero    [2];
  logic        rsp_fault   [2];
  logic [3:0]  rsp_tag     [2];
  logic        busy        [2];
  logic [15:0] txn_count   [2];
  logic [15:0] fault_count [2];

  // Glitch injection: overrides the behavioural ALU while inj_en is high.
  logic        inj_en  [2];
  alu_res_t    inj_val [2];

  // Reference model state.
  alu_res_t    exp_res  [2];
  logic [3:0]  exp_tag  [2];
  logic [4:0]  exp_code [2];
  logic [6:0]  exp_opm  [2];
  logic [63:0] exp_a    [2];
  logic [63:0] exp_b    [2];
  int          m_txn    [2];
  int          m_fault  [2];

  int n_checks = 0;
  int n_err    = 0;

  fop64_alu_sequencer #(.SETTLE_CYCLES(1), .TAG_W(4), .IDLE_CMD(IDLE_CMD)) dut_s1 (
    .clk(clk), .rst_n(rst_n[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_code(cmd_code[0]), .cmd_opm(cmd_opm[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_tag(cmd_tag[0]),
    .alu_cmd(alu_cmd[0]), .alu_opm(alu_opm[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_out(alu_res[0].out), .alu_regF(alu_res[0].flags), .alu_error(alu_res[0].err),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_out(rsp_out[0]), .rsp_flags(rsp_flags[0]), .rsp_error(rsp_error[0]),
    .rsp_neg(rsp_neg[0]), .rsp_zero(rsp_zero[0]), .rsp_fault(rsp_fault[0]),
    .rsp_tag(rsp_tag[0]), .busy(busy[0]),
    .txn_count(txn_count[0]), .fault_count(fault_count[0])
  );

  fop64_alu_sequencer #(.SETTLE_CYCLES(3), .TAG_W(4), .IDLE_CMD(IDLE_CMD)) dut_s3 (
    .clk(clk), .rst_n(rst_n[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_code(cmd_code[1]), .cmd_opm(cmd_opm[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_tag(cmd_tag[1]),
    .alu_cmd(alu_cmd[1]), .alu_opm(alu_opm[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_out(alu_res[1].out), .alu_regF(alu_res[1].flags), .alu_error(alu_res[1].err),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_out(rsp_out[1]), .rsp_flags(rsp_flags[1]), .rsp_error(rsp_error[1]),
    .rsp_neg(rsp_neg[1]), .rsp_zero(rsp_zero[1]), .rsp_fault(rsp_fault[1]),
    .rsp_tag(rsp_tag[1]), .busy(busy[1]),
    .txn_count(txn_count[1]), .fault_count(fault_count[1])
  );

  // Behavioural ALU: a handful of opcodes, flags bit 11 = zero, bit 9 = sign,
  // TRAP raises error bit 0 and forces a negative result.
  function automatic alu_res_t alu_fn(input logic [4:0] code, input logic [63:0] a,
                                      input logic [63:0] b);
    alu_res_t r;
    r = '0;
    case (code)
      OP_ADD:  r.out = a + b;
      OP_SUB:  r.out = a - b;
      OP_AND:  r.out = a & b;
      OP_OR:   r.out = a | b;
      OP_XOR:  r.out = a ^ b;
      OP_TRAP: begin
        r.out = a | 64'h8000_0000_0000_0000;
        r.err = 64'h1;
      end
      default: r.out = '0;
    endcase
    r.flags[11] = (r.out == 64'd0);
    r.flags[9]  = r.out[63];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      alu_res[i] = inj_en[i] ? inj_val[i] : alu_fn(alu_cmd[i], alu_a[i], alu_b[i]);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic set_exp(input int i, input logic [4:0] code, input logic [6:0] opm,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
    exp_code[i] = code;
    exp_opm[i]  = opm;
    exp_a[i]    = a;
    exp_b[i]    = b;
    exp_tag[i]  = tag;
    exp_res[i]  = alu_fn(code, a, b);
  endtask

  task automatic check_alu_driven(input int i, input string name);
    check({name, "_alu_cmd"}, 64'(alu_cmd[i]), 64'(exp_code[i]));
    check({name, "_alu_opm"}, 64'(alu_opm[i]), 64'(exp_opm[i]));
    check({name, "_alu_a"}, alu_a[i], exp_a[i]);
    check({name, "_alu_b"}, alu_b[i], exp_b[i]);
    check_b({name, "_cmd_ready"}, cmd_ready[i], 1'b0);
    check_b({name, "_busy"}, busy[i], 1'b1);
  endtask

  task automatic check_idle_outputs(input int i, input string name);
    check_b({name, "_cmd_ready"}, cmd_ready[i], 1'b1);
    check_b({name, "_rsp_valid"}, rsp_valid[i], 1'b0);
    check_b({name, "_busy"}, busy[i], 1'b0);
    check({name, "_alu_cmd"}, 64'(alu_cmd[i]), 64'(IDLE_CMD));
    check({name, "_alu_a"}, alu_a[i], 64'd0);
    check({name, "_txn_count"}, 64'(txn_count[i]), 64'd0);
    check({name, "_fault_count"}, 64'(fault_count[i]), 64'd0);
    check({name, "_rsp_out"}, rsp_out[i], 64'd0);
    check({name, "_rsp_tag"}, 64'(rsp_tag[i]), 64'd0);
  endtask

  // Offer a command at a negedge, let it be accepted on the next edge.
  task automatic issue(input int i, input logic [4:0] code, input logic [6:0] opm,
                       input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
    @(negedge clk);
    cmd_valid[i] = 1'b1;
    cmd_code[i]  = code;
    cmd_opm[i]   = opm;
    cmd_a[i]     = a;
    cmd_b[i]     = b;
    cmd_tag[i]   = tag;
    check_b("issue_cmd_ready", cmd_ready[i], 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid[i] = 1'b0;
    set_exp(i, code, opm, a, b, tag);
    check_alu_driven(i, "accept");
    check_b("accept_rsp_valid", rsp_valid[i], 1'b0);
  endtask

  // Count edges until rsp_valid, optionally glitching the ALU after edge N+2.
  task automatic wait_rsp(input int i, input bit glitch);
    int cyc;
    cyc = 0;
    while (rsp_valid[i] !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      cyc++;
      if (glitch && cyc == 2) begin
        #1;
        inj_val[i].out   = ~exp_res[i].out;
        inj_val[i].flags = 64'hFFFF;
        inj_val[i].err   = 64'hDEAD;
        inj_en[i]        = 1'b1;
      end
      @(negedge clk);
      inj_en[i] = 1'b0;
      if (rsp_valid[i] !== 1'b1) check_alu_driven(i, "settle");
    end
    check("rsp_latency", 64'(cyc), 64'(settle_of(i)));
    check("rsp_out", rsp_out[i], exp_res[i].out);
    check("rsp_flags", rsp_flags[i], exp_res[i].flags);
    check("rsp_error", rsp_error[i], exp_res[i].err);
    check_b("rsp_neg", rsp_neg[i], exp_res[i].flags[9]);
    check_b("rsp_zero", rsp_zero[i], exp_res[i].flags[11]);
    check_b("rsp_fault", rsp_fault[i], |exp_res[i].err);
    check("rsp_tag", 64'(rsp_tag[i]), 64'(exp_tag[i]));
    check("rsp_alu_cmd_idle", 64'(alu_cmd[i]), 64'(IDLE_CMD));
    check("rsp_alu_a_zero", alu_a[i], 64'd0);
    check("rsp_alu_b_zero", alu_b[i], 64'd0);
    check("rsp_alu_opm_zero", 64'(alu_opm[i]), 64'd0);
    check_b("rsp_cmd_ready", cmd_ready[i], 1'b0);
  endtask

  task automatic model_complete(input int i);
    m_txn[i] = (m_txn[i] + 1) % 65536;
    if (exp_res[i].err != 64'd0 && m_fault[i] < 65535) m_fault[i]++;
  endtask

  task automatic check_after_hs(input int i);
    check_b("hs_rsp_valid", rsp_valid[i], 1'b0);
    check_b("hs_cmd_ready", cmd_ready[i], 1'b1);
    check_b("hs_busy", busy[i], 1'b0);
    check("hs_txn_count", 64'(txn_count[i]), 64'(m_txn[i]));
    check("hs_fault_count", 64'(fault_count[i]), 64'(m_fault[i]));
    check("hs_rsp_out_kept", rsp_out[i], exp_res[i].out);
    check("hs_rsp_tag_kept", 64'(rsp_tag[i]), 64'(exp_tag[i]));
  endtask

  // Hold rsp_ready low for `hold` cycles, then take the response.
  task automatic handshake(input int i, input int hold);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_b("bp_rsp_valid", rsp_valid[i], 1'b1);
      check("bp_rsp_out", rsp_out[i], exp_res[i].out);
      check_b("bp_cmd_ready", cmd_ready[i], 1'b0);
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    model_complete(i);
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    check_after_hs(i);
  endtask

  task automatic reset_now(input int i);
    rst_n[i] = 1'b0;
    #1;
    check_idle_outputs(i, "async_rst");
    m_txn[i]   = 0;
    m_fault[i] = 0;
    @(negedge clk);
    rst_n[i] = 1'b1;
  endtask

  vec_t        vecs [7];
  logic [4:0]  codes [8];

  initial begin
    vecs[0] = '{OP_OR,   64'hF0F0F0, 64'h0F0F0F, 4'd3, 0, 64'h0000_0000_00FF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{OP_AND,  64'hB, 64'h7, 4'd5, 5, 64'h3, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{OP_XOR,  64'h1234, 64'h1234, 4'd6, 1, 64'h0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{OP_SUB,  64'h0, 64'h1, 4'd7, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd8, 0, 64'h0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{OP_TRAP, 64'h5, 64'h0, 4'd15, 3, 64'h8000_0000_0000_0005, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{OP_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd0, 0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    codes = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_TRAP, 5'b01010, IDLE_CMD};

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_code[i] = '0; cmd_opm[i] = '0;
      cmd_a[i] = '0; cmd_b[i] = '0; cmd_tag[i] = '0; rsp_ready[i] = 1'b0;
      inj_en[i] = 1'b0; inj_val[i] = '0; m_txn[i] = 0; m_fault[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) check_idle_outputs(i, "por");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Table-driven vectors on the SETTLE_CYCLES=1 instance.
    for (int v = 0; v < 7; v++) begin
      issue(0, vecs[v].code, 7'h11, vecs[v].a, vecs[v].b, vecs[v].tag);
      wait_rsp(0, 1'b0);
      check("vec_out", rsp_out[0], vecs[v].exp_out);
      check_b("vec_zero", rsp_zero[0], vecs[v].exp_zero);
      check_b("vec_neg", rsp_neg[0], vecs[v].exp_neg);
      check_b("vec_fault", rsp_fault[0], vecs[v].exp_fault);
      check("vec_tag", 64'(rsp_tag[0]), 64'(vecs[v].tag));
      handshake(0, vecs[v].hold);
      if (v == 0) check("vec_first_txn_count", 64'(txn_count[0]), 64'd1);
    end

    // Backpressure with a second command offered during the stall.
    issue(0, OP_AND, 7'h02, 64'hB, 64'h7, 4'h9);
    wait_rsp(0, 1'b0);
    cmd_valid[0] = 1'b1; cmd_code[0] = OP_OR; cmd_opm[0] = 7'h05;
    cmd_a[0] = 64'h1; cmd_b[0] = 64'h2; cmd_tag[0] = 4'hA;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp2_rsp_out", rsp_out[0], 64'h3);
      check_b("bp2_rsp_valid", rsp_valid[0], 1'b1);
      check_b("bp2_cmd_ready", cmd_ready[0], 1'b0);
      check("bp2_not_accepted", 64'(alu_cmd[0]), 64'(IDLE_CMD));
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    model_complete(0);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check_after_hs(0);
    check("bp2_not_on_hs_edge", 64'(alu_cmd[0]), 64'(IDLE_CMD));
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    set_exp(0, OP_OR, 7'h05, 64'h1, 64'h2, 4'hA);
    check_alu_driven(0, "bp2_accept");
    wait_rsp(0, 1'b0);
    handshake(0, 0);

    // Fault counter saturation and transaction counter wrap.
    @(negedge clk);
    force dut_s1.fault_count = 16'hFFFE;
    force dut_s1.txn_count   = 16'hFFFE;
    #1;
    release dut_s1.fault_count;
    release dut_s1.txn_count;
    m_fault[0] = 65534;
    m_txn[0]   = 65534;
    for (int k = 0; k < 3; k++) begin
      issue(0, OP_TRAP, 7'h00, 64'(k), 64'h0, 4'(k));
      wait_rsp(0, 1'b0);
      handshake(0, 0);
    end
    check("sat_fault_count", 64'(fault_count[0]), 64'hFFFF);
    check("wrap_txn_count", 64'(txn_count[0]), 64'h1);

    // Asynchronous reset in the middle of a cycle while in RESP.
    issue(0, OP_OR, 7'h01, 64'hFF, 64'h0, 4'h4);
    wait_rsp(0, 1'b0);
    #2;
    reset_now(0);

    // SETTLE_CYCLES=3: glitch on the ALU between edges N+2 and N+3.
    issue(1, OP_ADD, 7'h33, 64'h1111, 64'h2222, 4'hC);
    wait_rsp(1, 1'b1);
    check("glitch_rsp_out", rsp_out[1], 64'h3333);
    handshake(1, 0);

    // Reset during DRIVE drops the transaction silently.
    issue(1, OP_XOR, 7'h00, 64'hAA, 64'h55, 4'h2);
    @(posedge clk);
    #2;
    reset_now(1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_b("drop_no_rsp", rsp_valid[1], 1'b0);
    end
    issue(1, OP_SUB, 7'h00, 64'h10, 64'h3, 4'h1);
    wait_rsp(1, 1'b0);
    handshake(1, 1);
    check("drop_txn_count", 64'(txn_count[1]), 64'd1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 30; n++) begin
        logic [63:0] a;
        logic [63:0] b;
        bit          early;
        int          hold;
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 4) == 0) ? a : {$urandom, $urandom};
        early = ($urandom_range(0, 3) == 0);
        hold  = early ? 0 : int'($urandom_range(0, 3));
        issue(i, codes[$urandom_range(0, 7)], 7'($urandom), a, b, 4'($urandom));
        if (early) rsp_ready[i] = 1'b1;
        wait_rsp(i, 1'b0);
        handshake(i, hold);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
